dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-index width (2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 2, accept-to-response cycles; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, memory stage presents a load/store.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data.
REQ-009 SHALL have port flush, input, 1, abort any in-flight request.
REQ-010 SHALL have port req_ready, output, 1, request accepted this cycle.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 32, load data; valid only with rsp_valid.
REQ-013 SHALL have port rsp_err, output, 1, misaligned access; valid only with rsp_valid.
REQ-014 SHALL have port stall, output, 1, pipeline hold request to the core.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL equal (state==IDLE) && !flush; accept occurs on req_valid && req_ready.
REQ-017 On accept, SHALL latch we, addr, wdata and go to RESP if LATENCY==1, else to WAIT with counter = LATENCY-1.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle it reaches 1.
REQ-019 In RESP, SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 A store SHALL commit to the array only on the RESP cycle edge, at index addr[ADDR_W+1:2].
REQ-021 A load SHALL return the array word at the latched index, sampled in RESP; a store SHALL drive rsp_rdata = 0.
REQ-022 Address bits above ADDR_W+1 SHALL be ignored (index wraps modulo 2^ADDR_W).
REQ-023 If latched addr[1:0] != 0: no array write, rsp_err = 1, rsp_rdata = 0, timing unchanged.
REQ-024 stall SHALL equal req_valid && !rsp_valid (combinational), so the stage advances on the RESP cycle.
REQ-025 flush in WAIT or RESP SHALL return the FSM to IDLE next edge with no write, no rsp_valid, and no accept that cycle.
REQ-026 req_valid deasserting while in WAIT SHALL NOT cancel the request; only flush or reset cancels.
REQ-027 A new request SHALL NOT be accepted in the RESP cycle; back-to-back throughput is one per LATENCY+1 cycles.

Reset
REQ-028 reset_n low SHALL immediately force state = IDLE, counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, latched request = 0.
REQ-029 Reset mid-operation SHALL discard the pending request; a pending store SHALL NOT be written.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 FSM state encoding and the LATENCY legal-range bounds SHALL live in the shared package for core memory-side blocks.
REQ-032 The storage array SHALL be one sub-module, dmem_array (synchronous write, combinational read).

Verification
REQ-033 LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid 2 cycles after each accept, load rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 Load at 0x13 -> rsp_err = 1, rdata = 0; a following load at 0x10 still returns the prior value (no corruption).
REQ-035 Store 0x12345678 to 0x104 (ADDR_W=6), then load 0x004 -> 0x12345678 (wrap).
REQ-036 Store issued, flush pulsed one cycle after accept -> no rsp_valid; later load of the same address returns the old value.
REQ-037 reset_n low during WAIT of a store -> outputs zero immediately; FSM in IDLE, req_ready = 1 after release; array unchanged.
REQ-038 req_valid held high for 3 loads, LATENCY=1 -> stall pattern 1,0,1,0,1,0; accepts on cycles 0, 2, 4.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared types and constants for core memory-side blocks.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Legal accept-to-response latency window
    localparam int c_latency_min = 1;
    localparam int c_latency_max = 15;

    // Wide enough to hold c_latency_max - 1
    localparam int c_cnt_w = 4;

    // Counter value loaded on accept; WAIT leaves for RESP once it holds 1
    function automatic logic [c_cnt_w-1:0] wait_count(input int lat);
        return c_cnt_w'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : 2^ADDR_W x 32 word store, synchronous write, combinational read.
//            Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder for the core memory stage.
//            Accepts one load/store, responds LATENCY cycles later, and
//            supports flush and asynchronous reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    // Reject out-of-range latency at elaboration
    if (LATENCY < c_latency_min || LATENCY > c_latency_max) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range");
    end

    dmem_state_e          state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [ADDR_W+1:0]    addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;

    logic                 arr_we;
    logic [31:0]          arr_rdata;
    logic                 misaligned;

    // Address bits above the word index are intentionally discarded
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign misaligned = (addr_q[1:0] != 2'b00);

    // State and latched-request registers, cleared immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, accept handshake, response pulse and array write strobe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        arr_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = wait_count(LATENCY);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // req_valid is not consulted: only flush or reset cancels
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= c_cnt_w'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - c_cnt_w'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    rsp_valid = 1'b1;
                    arr_we    = we_q && !misaligned;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rsp_err   = rsp_valid && misaligned;
    assign rsp_rdata = (rsp_valid && !we_q && !misaligned) ? arr_rdata : 32'h0;
    assign stall     = req_valid && !rsp_valid;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_we),
        .idx   (addr_q[ADDR_W+1:2]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        v2, we2, fl2;
    logic [31:0] a2, wd2;
    logic        rdy2, rv2, err2, st2;
    logic [31:0] rd2;

    logic        v1, we1, fl1;
    logic [31:0] a1, wd1;
    logic        rdy1, rv1, err1, st1;
    logic [31:0] rd1;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (v2),
        .req_we    (we2),
        .req_addr  (a2),
        .req_wdata (wd2),
        .flush     (fl2),
        .req_ready (rdy2),
        .rsp_valid (rv2),
        .rsp_rdata (rd2),
        .rsp_err   (err2),
        .stall     (st2)
    );

    dmem_responder #(.ADDR_W(6), .LATENCY(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (v1),
        .req_we    (we1),
        .req_addr  (a1),
        .req_wdata (wd1),
        .flush     (fl1),
        .req_ready (rdy1),
        .rsp_valid (rv1),
        .rsp_rdata (rd1),
        .rsp_err   (err1),
        .stall     (st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full request on the LATENCY=2 instance; called about 1-2 time units after a rising edge
    task automatic req2(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input logic hold);
        v2 = 1'b1; we2 = we; a2 = addr; wd2 = wdata;
        #1;
        chk({tag, ".ready"}, 32'(rdy2), 32'd1);
        chk({tag, ".stall_acc"}, 32'(st2), 32'd1);
        @(posedge clk); #1;
        if (!hold) v2 = 1'b0;
        #1;
        chk({tag, ".rv_wait"}, 32'(rv2), 32'd0);
        chk({tag, ".stall_wait"}, 32'(st2), 32'(hold));
        @(posedge clk); #2;
        chk({tag, ".rv_resp"}, 32'(rv2), 32'd1);
        chk({tag, ".rdata"}, rd2, exp_rd);
        chk({tag, ".err"}, 32'(err2), 32'(exp_err));
        chk({tag, ".ready_resp"}, 32'(rdy2), 32'd0);
        chk({tag, ".stall_resp"}, 32'(st2), 32'd0);
        @(posedge clk); #1;
        v2 = 1'b0;
        #1;
        chk({tag, ".rv_after"}, 32'(rv2), 32'd0);
        chk({tag, ".ready_after"}, 32'(rdy2), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        v2 = 1'b0; we2 = 1'b0; fl2 = 1'b0; a2 = '0; wd2 = '0;
        v1 = 1'b0; we1 = 1'b0; fl1 = 1'b0; a1 = '0; wd1 = '0;
        #2;
        chk("rst.rv",    32'(rv2),  32'd0);
        chk("rst.rdata", rd2,       32'd0);
        chk("rst.err",   32'(err2), 32'd0);
        chk("rst.ready", 32'(rdy2), 32'd1);
        chk("rst.stall", 32'(st2),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic store/load, then misaligned load and store
        req2("st10",  1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
        req2("ld10",  1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        req2("ld13",  1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1'b1);
        req2("st11",  1'b1, 32'h11,  32'hBAD0BAD0, 32'h0,        1'b1, 1'b1);
        req2("ld10b", 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1);

        // Index wrap modulo 64 words
        req2("st104", 1'b1, 32'h104, 32'h12345678, 32'h0,        1'b0, 1'b1);
        req2("ld004", 1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0, 1'b1);

        // Flush one cycle after accepting a store
        v2 = 1'b1; we2 = 1'b1; a2 = 32'h10; wd2 = 32'hCAFEF00D;
        #1;
        chk("fl.ready", 32'(rdy2), 32'd1);
        @(posedge clk); #1;
        v2 = 1'b0; fl2 = 1'b1;
        #1;
        chk("fl.rv_wait", 32'(rv2), 32'd0);
        chk("fl.ready_flush", 32'(rdy2), 32'd0);
        @(posedge clk); #1;
        fl2 = 1'b0;
        #1;
        chk("fl.rv_idle", 32'(rv2), 32'd0);
        chk("fl.ready_idle", 32'(rdy2), 32'd1);
        @(posedge clk); #2;
        chk("fl.rv_late", 32'(rv2), 32'd0);
        req2("ld10fl", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Asynchronous reset during WAIT of a store
        v2 = 1'b1; we2 = 1'b1; a2 = 32'h10; wd2 = 32'h55555555;
        #1;
        chk("rw.ready", 32'(rdy2), 32'd1);
        @(posedge clk); #1;
        v2 = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rw.rv",    32'(rv2),  32'd0);
        chk("rw.rdata", rd2,       32'd0);
        chk("rw.err",   32'(err2), 32'd0);
        chk("rw.ready_in_reset", 32'(rdy2), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("rw.ready_after", 32'(rdy2), 32'd1);
        chk("rw.rv_after", 32'(rv2), 32'd0);
        @(posedge clk); #2;
        chk("rw.rv_late", 32'(rv2), 32'd0);
        req2("ld10rw", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // LATENCY=1: three back-to-back loads with req_valid held high
        v1 = 1'b1; we1 = 1'b0; a1 = 32'h0;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("l1.stall%0d", i), 32'(st1),  32'((i % 2) == 0));
            chk($sformatf("l1.rv%0d", i),    32'(rv1),  32'((i % 2) == 1));
            chk($sformatf("l1.ready%0d", i), 32'(rdy1), 32'((i % 2) == 0));
            @(posedge clk); #2;
        end
        v1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
